// File: rtl/ireg_writeback_queue.sv
// Writeback queue for the 64x32 register file; drains when read port 0 is idle or a write is overdue.
// Optional RAW hazard check (chk_addr/chk_busy) is built when IREG_WB_HAZARD_EN is defined.
module ireg_writeback_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AW         = 6,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef IREG_WB_HAZARD_EN
  input  logic [AW-1:0]            chk_addr,
  output logic                     chk_busy,
`endif
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_addr,
  input  logic [DW-1:0]            alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [AW-1:0]            ld_addr,
  input  logic [DW-1:0]            ld_data,
  input  logic                     rd0_req,
  output logic                     rd0_grant,
  output logic [AW-1:0]            rw,
  output logic [DW-1:0]            dw,
  output logic                     we,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          push_alu, push_ld, push, starve_hit;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;

  always_comb begin
    full       = rst_n && (count_q == CW'(DEPTH));
    empty      = !rst_n || (count_q == '0);
    alu_ready  = rst_n && !full;
    ld_ready   = rst_n && !full && !alu_valid;
    push_alu   = alu_valid && alu_ready;
    push_ld    = ld_valid && ld_ready;
    push       = push_alu || push_ld;
    in_addr    = push_alu ? alu_addr : ld_addr;
    in_data    = push_alu ? alu_data : ld_data;
    starve_hit = (starve_q == SW'(STARVE_MAX));
    // Full or overdue entries take port 0 even if the read stage wants it.
    we         = rst_n && !empty && (!rd0_req || full || starve_hit);
    rd0_grant  = !we;
    rw         = addr_q[rd_ptr_q];
    dw         = data_q[rd_ptr_q];
    count      = count_q;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(we);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(we);
    starve_d = starve_q;
    if (we || empty) begin
      starve_d = '0;
    end else if (!starve_hit) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= in_addr;
      data_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef IREG_WB_HAZARD_EN
  always_comb begin
    chk_busy = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rst_n && (CW'(i) < count_q) && (addr_q[rd_ptr_q + PW'(i)] == chk_addr)) begin
        chk_busy = 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ireg_writeback_queue.sv
// Bench for ireg_writeback_queue: directed steps plus random traffic against a queue-based model.
// Hazard-port checks are included when IREG_WB_HAZARD_EN is defined.
module tb_ireg_writeback_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int SMAX  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid = 1'b0, ld_valid = 1'b0, rd0_req = 1'b0;
  logic [AW-1:0] alu_addr = '0, ld_addr = '0;
  logic [DW-1:0] alu_data = '0, ld_data = '0;
  logic          alu_ready, ld_ready, rd0_grant, we, full, empty;
  logic [AW-1:0] rw;
  logic [DW-1:0] dw;
  logic [2:0]    count;
`ifdef IREG_WB_HAZARD_EN
  logic [AW-1:0] chk_addr = '0;
  logic          chk_busy;
`endif

  always #5 clk = ~clk;

  ireg_writeback_queue #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef IREG_WB_HAZARD_EN
    .chk_addr(chk_addr), .chk_busy(chk_busy),
`endif
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd0_req(rd0_req), .rd0_grant(rd0_grant), .rw(rw), .dw(dw), .we(we),
    .count(count), .full(full), .empty(empty)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  int   starve = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cycle();
    bit   e_full, e_empty, e_we, e_busy;
    ent_t ent;
    #3;
    if (!rst_n) begin
      chk("rst_alu_ready", alu_ready, 0);
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_we", we, 0);
      chk("rst_rd0_grant", rd0_grant, 1);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
`ifdef IREG_WB_HAZARD_EN
      chk("rst_chk_busy", chk_busy, 0);
`endif
      e_we = 1'b0;
      e_full = 1'b0;
    end else begin
      e_full  = (q.size() == DEPTH);
      e_empty = (q.size() == 0);
      e_we    = !e_empty && (!rd0_req || e_full || starve == SMAX);
      chk("count", count, q.size());
      chk("full", full, e_full);
      chk("empty", empty, e_empty);
      chk("alu_ready", alu_ready, !e_full);
      chk("ld_ready", ld_ready, !e_full && !alu_valid);
      chk("we", we, e_we);
      chk("rd0_grant", rd0_grant, !e_we);
      if (e_we) begin
        chk("rw", rw, q[0].a);
        chk("dw", dw, q[0].d);
      end
`ifdef IREG_WB_HAZARD_EN
      e_busy = 1'b0;
      foreach (q[i]) if (q[i].a == chk_addr) e_busy = 1'b1;
      chk("chk_busy", chk_busy, e_busy);
`endif
    end
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      starve = 0;
    end else begin
      e_empty = (q.size() == 0);
      if (e_we) begin
        void'(q.pop_front());
        starve = 0;
      end else if (e_empty) begin
        starve = 0;
      end else if (starve < SMAX) begin
        starve++;
      end
      if (!e_full && alu_valid) begin
        ent.a = alu_addr; ent.d = alu_data; q.push_back(ent);
      end else if (!e_full && ld_valid) begin
        ent.a = ld_addr; ent.d = ld_data; q.push_back(ent);
      end
    end
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // Reset held with a pending ALU request.
    alu_valid = 1'b1; alu_addr = 6'd9; alu_data = 32'hdead;
    cycles(3);
    rst_n = 1'b1; alu_valid = 1'b0;
    cycle();

    // Single ALU write with port 0 idle.
    alu_valid = 1'b1; alu_addr = 6'd5; alu_data = 32'h11; rd0_req = 1'b0;
    cycle();
    alu_valid = 1'b0;
    cycles(2);

    // ALU beats load; load follows next cycle; writes in that order.
    rd0_req = 1'b1;
    alu_valid = 1'b1; alu_addr = 6'd1; alu_data = 32'haa;
    ld_valid = 1'b1; ld_addr = 6'd2; ld_data = 32'hbb;
    cycle();
    alu_valid = 1'b0;
    cycle();
    ld_valid = 1'b0; rd0_req = 1'b0;
    cycles(3);

    // Starvation: one entry held off by the read stage until forced.
    rd0_req = 1'b1;
    alu_valid = 1'b1; alu_addr = 6'd3; alu_data = 32'h33;
    cycle();
    alu_valid = 1'b0;
    cycles(12);

    // Fill to full under read pressure; full forces drains.
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_addr = 6'(10 + i); alu_data = 32'h100 + i;
      cycle();
    end
    alu_valid = 1'b0;
    cycles(20);

    // Reset mid-operation drops queued entries.
    alu_valid = 1'b1; alu_addr = 6'd0; alu_data = 32'h55;
    cycles(2);
    alu_valid = 1'b0; rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycles(2);

`ifdef IREG_WB_HAZARD_EN
    chk_addr = 6'd7; rd0_req = 1'b1;
    alu_valid = 1'b1; alu_addr = 6'd7; alu_data = 32'h77;
    cycle();
    alu_valid = 1'b0;
    cycles(3);
    rd0_req = 1'b0;
    cycles(2);
    chk_addr = 6'd8; rd0_req = 1'b1;
    alu_valid = 1'b1; alu_addr = 6'd7; alu_data = 32'h78;
    cycle();
    alu_valid = 1'b0;
    cycles(10);
`endif

    // Random traffic, addresses from a small pool so repeats are common.
    for (int i = 0; i < 400; i++) begin
      rd0_req   = ($urandom_range(0, 3) != 0);
      alu_valid = ($urandom_range(0, 2) == 0);
      ld_valid  = ($urandom_range(0, 2) == 0);
      alu_addr  = 6'($urandom_range(0, 15));
      ld_addr   = 6'($urandom_range(0, 15));
      alu_data  = $urandom;
      ld_data   = $urandom;
`ifdef IREG_WB_HAZARD_EN
      chk_addr  = 6'($urandom_range(0, 15));
`endif
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      cycle();
    end
    rst_n = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0; rd0_req = 1'b0;
    cycles(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
